// File: rtl/vr_cdc_bus_receiver.sv
// Destination end of a toggle req/ack bus crossing into dst_clk.
// Synchronizes the request, captures the held source word and returns an ack toggle on accept.
//
// state | meaning
// IDLE  | no word pending; watching the synchronized request for a new toggle
// BUSY  | captured word presented on dst_valid/dst_data until the consumer accepts it
module vr_cdc_bus_receiver #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             dst_clk,
  input  logic             rstn,
  input  logic             src_req_tgl,
  input  logic [WIDTH-1:0] src_data,
  output logic             dst_valid,
  input  logic             dst_ready,
  output logic [WIDTH-1:0] dst_data,
  output logic             dst_ack_tgl,
  output logic             proto_err,
  output logic [CNT_W-1:0] xfer_cnt
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [DEPTH-1:0] req_s;
  logic             req_sync;
  logic             req_seen;
  logic [0:0]       state;

  always_ff @(posedge dst_clk or negedge rstn) begin
    if (!rstn) req_s <= '0;
    else       req_s <= {req_s[DEPTH-2:0], src_req_tgl};
  end

  assign req_sync = req_s[DEPTH-1];

  // src_data is only sampled on the capture edge; the source holds it until it sees our ack.
  always_ff @(posedge dst_clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      req_seen    <= 1'b0;
      dst_valid   <= 1'b0;
      dst_data    <= '0;
      dst_ack_tgl <= 1'b0;
      proto_err   <= 1'b0;
      xfer_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_sync != req_seen) begin
            dst_data  <= src_data;
            req_seen  <= req_sync;
            dst_valid <= 1'b1;
            state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // an extra toggle here is flagged only; it is serviced as a fresh request back in IDLE
          if (req_sync != req_seen) proto_err <= 1'b1;
          if (dst_valid && dst_ready) begin
            dst_valid   <= 1'b0;
            dst_ack_tgl <= ~dst_ack_tgl;
            xfer_cnt    <= xfer_cnt + CNT_W'(1);
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vr_cdc_bus_receiver.sv
// Bench for vr_cdc_bus_receiver: directed protocol scenarios plus a randomized
// handshake run checked against a queue-based model of the words sent.
module tb_vr_cdc_bus_receiver;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;
  localparam int CNT_W = 8;

  logic             dst_clk = 1'b0;
  logic             rstn;
  logic             src_req_tgl;
  logic [WIDTH-1:0] src_data;
  logic             dst_valid;
  logic             dst_ready;
  logic [WIDTH-1:0] dst_data;
  logic             dst_ack_tgl;
  logic             proto_err;
  logic [CNT_W-1:0] xfer_cnt;

  int checks = 0;
  int errors = 0;
  logic req_lvl = 1'b0;
  int   exp_cnt = 0;
  logic ack_s0, ack_s1;
  logic [WIDTH-1:0] sent_q[$];

  vr_cdc_bus_receiver #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .dst_clk(dst_clk), .rstn(rstn), .src_req_tgl(src_req_tgl), .src_data(src_data),
    .dst_valid(dst_valid), .dst_ready(dst_ready), .dst_data(dst_data),
    .dst_ack_tgl(dst_ack_tgl), .proto_err(proto_err), .xfer_cnt(xfer_cnt)
  );

  always #5 dst_clk = ~dst_clk;

  // source-domain synchronizer for the returned ack (same clock here for simplicity)
  always_ff @(posedge dst_clk or negedge rstn) begin
    if (!rstn) begin
      ack_s0 <= 1'b0;
      ack_s1 <= 1'b0;
    end else begin
      ack_s0 <= dst_ack_tgl;
      ack_s1 <= ack_s0;
    end
  end

  task automatic do_reset();
    rstn = 1'b0;
    req_lvl = 1'b0;
    src_req_tgl = 1'b0;
    src_data = '0;
    dst_ready = 1'b0;
    exp_cnt = 0;
    sent_q.delete();
    repeat (2) @(negedge dst_clk);
    rstn = 1'b1;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] d);
    src_data = d;
    req_lvl = ~req_lvl;
    src_req_tgl = req_lvl;
  endtask

  task automatic wait_valid(input string name);
    int t = 0;
    while (dst_valid !== 1'b1 && t < 20) begin
      @(negedge dst_clk);
      t++;
    end
    checks++;
    if (dst_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s wait_valid: dst_valid=%b required 1 within 20 cycles", name, dst_valid);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    src_req_tgl = 1'b1;
    src_data = 8'h5A;
    dst_ready = 1'b0;
    #1;
    checks++;
    if ({dst_valid, dst_ack_tgl, proto_err, dst_data, xfer_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b ack=%b err=%b data=%h cnt=%0d required all 0",
               dst_valid, dst_ack_tgl, proto_err, dst_data, xfer_cnt);
    end
    @(negedge dst_clk);
    rstn = 1'b1;
    req_lvl = 1'b1;
    for (int e = 1; e <= DEPTH + 1; e++) begin
      @(negedge dst_clk);
      checks++;
      if (dst_valid !== (e == DEPTH + 1)) begin
        errors++;
        $display("FAIL reset_pending_req edge %0d: dst_valid=%b required %b", e, dst_valid, e == DEPTH + 1);
      end
    end
    checks++;
    if (dst_data !== 8'h5A) begin
      errors++;
      $display("FAIL reset_pending_data: dst_data=%h required 5a", dst_data);
    end
  endtask

  task automatic test_single();
    do_reset();
    @(negedge dst_clk);
    dst_ready = 1'b1;
    send_word(8'hA5);
    for (int e = 1; e <= DEPTH + 2; e++) begin
      @(negedge dst_clk);
      checks++;
      if (dst_valid !== (e == DEPTH + 1)) begin
        errors++;
        $display("FAIL single_valid edge %0d: dst_valid=%b required %b", e, dst_valid, e == DEPTH + 1);
      end
      if (e == DEPTH + 1) begin
        checks++;
        if (dst_data !== 8'hA5 || dst_ack_tgl !== 1'b0) begin
          errors++;
          $display("FAIL single_capture: data=%h ack=%b required a5 0", dst_data, dst_ack_tgl);
        end
      end
    end
    checks++;
    if (dst_ack_tgl !== 1'b1 || xfer_cnt !== 8'd1) begin
      errors++;
      $display("FAIL single_accept: ack=%b cnt=%0d required 1 1", dst_ack_tgl, xfer_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic ack0;
    logic [CNT_W-1:0] cnt0;
    @(negedge dst_clk);
    dst_ready = 1'b0;
    ack0 = dst_ack_tgl;
    cnt0 = xfer_cnt;
    send_word(8'h3C);
    wait_valid("backpressure");
    for (int i = 0; i < 10; i++) begin
      @(negedge dst_clk);
      checks++;
      if (dst_valid !== 1'b1 || dst_data !== 8'h3C || dst_ack_tgl !== ack0) begin
        errors++;
        $display("FAIL backpressure_hold cyc %0d: valid=%b data=%h ack=%b required 1 3c %b",
                 i, dst_valid, dst_data, dst_ack_tgl, ack0);
      end
    end
    dst_ready = 1'b1;
    @(negedge dst_clk);
    checks++;
    if (dst_valid !== 1'b0 || dst_ack_tgl !== ~ack0 || xfer_cnt !== cnt0 + 8'd1) begin
      errors++;
      $display("FAIL backpressure_accept: valid=%b ack=%b cnt=%0d required 0 %b %0d",
               dst_valid, dst_ack_tgl, xfer_cnt, ~ack0, cnt0 + 8'd1);
    end
    repeat (3) @(negedge dst_clk);
    checks++;
    if (dst_ack_tgl !== ~ack0 || dst_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_single_ack: ack=%b valid=%b required %b 0", dst_ack_tgl, dst_valid, ~ack0);
    end
  endtask

  task automatic test_back_to_back();
    int rx = 0;
    do_reset();
    fork
      begin : source
        for (int i = 0; i < 300; i++) begin
          int t = 0;
          logic [WIDTH-1:0] d;
          while (ack_s1 !== req_lvl && t < 2000) begin
            @(negedge dst_clk);
            t++;
          end
          if (ack_s1 !== req_lvl) begin
            checks++;
            errors++;
            $display("FAIL b2b_source_timeout word %0d: ack_sync=%b required %b", i, ack_s1, req_lvl);
            break;
          end
          d = WIDTH'($urandom);
          sent_q.push_back(d);
          exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
          send_word(d);
          @(negedge dst_clk);
        end
      end
      begin : consumer
        int cyc = 0;
        while (rx < 300 && cyc < 30000) begin
          @(negedge dst_clk);
          cyc++;
          dst_ready = ($urandom_range(0, 2) != 0);
          if (dst_valid === 1'b1 && dst_ready) begin
            checks++;
            if (sent_q.size() == 0) begin
              errors++;
              $display("FAIL b2b_spurious word %0d: data=%h required no word", rx, dst_data);
            end else begin
              logic [WIDTH-1:0] exp_d;
              exp_d = sent_q.pop_front();
              if (dst_data !== exp_d) begin
                errors++;
                $display("FAIL b2b_data word %0d: data=%h required %h", rx, dst_data, exp_d);
              end
            end
            rx++;
          end
        end
        checks++;
        if (rx != 300) begin
          errors++;
          $display("FAIL b2b_timeout: received %0d words required 300", rx);
        end
      end
    join
    @(negedge dst_clk);
    dst_ready = 1'b0;
    checks++;
    if (xfer_cnt !== CNT_W'(exp_cnt) || xfer_cnt !== CNT_W'(44)) begin
      errors++;
      $display("FAIL b2b_count: xfer_cnt=%0d required %0d", xfer_cnt, 44);
    end
    checks++;
    if (proto_err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_proto_err: proto_err=%b required 0", proto_err);
    end
  endtask

  task automatic test_proto_violation();
    do_reset();
    @(negedge dst_clk);
    send_word(8'h11);
    wait_valid("proto_first");
    send_word(8'h22);
    repeat (DEPTH + 2) @(negedge dst_clk);
    checks++;
    if (proto_err !== 1'b1 || dst_data !== 8'h11 || dst_valid !== 1'b1) begin
      errors++;
      $display("FAIL proto_flag: err=%b data=%h valid=%b required 1 11 1", proto_err, dst_data, dst_valid);
    end
    dst_ready = 1'b1;
    @(negedge dst_clk);
    dst_ready = 1'b0;
    checks++;
    if (dst_valid !== 1'b0 || dst_ack_tgl !== 1'b1 || proto_err !== 1'b1) begin
      errors++;
      $display("FAIL proto_accept: valid=%b ack=%b err=%b required 0 1 1", dst_valid, dst_ack_tgl, proto_err);
    end
    @(negedge dst_clk);
    checks++;
    if (dst_valid !== 1'b1 || dst_data !== 8'h22) begin
      errors++;
      $display("FAIL proto_reservice: valid=%b data=%h required 1 22", dst_valid, dst_data);
    end
    dst_ready = 1'b1;
    @(negedge dst_clk);
    dst_ready = 1'b0;
    repeat (3) @(negedge dst_clk);
    checks++;
    if (proto_err !== 1'b1 || xfer_cnt !== 8'd2 || dst_ack_tgl !== 1'b0) begin
      errors++;
      $display("FAIL proto_sticky: err=%b cnt=%0d ack=%b required 1 2 0", proto_err, xfer_cnt, dst_ack_tgl);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (proto_err !== 1'b0) begin
      errors++;
      $display("FAIL proto_clear: proto_err=%b required 0", proto_err);
    end
    @(negedge dst_clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset_mid_transfer();
    do_reset();
    @(negedge dst_clk);
    dst_ready = 1'b1;
    send_word(8'h66);
    repeat (DEPTH + 3) @(negedge dst_clk);
    dst_ready = 1'b0;
    send_word(8'h77);
    wait_valid("mid_reset");
    checks++;
    if (xfer_cnt !== 8'd1 || dst_ack_tgl !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_pre: cnt=%0d ack=%b required 1 1", xfer_cnt, dst_ack_tgl);
    end
    #2;
    rstn = 1'b0;
    req_lvl = 1'b0;
    src_req_tgl = 1'b0;
    #1;
    checks++;
    if (dst_valid !== 1'b0 || dst_ack_tgl !== 1'b0 || xfer_cnt !== 8'd0 || dst_data !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_async: valid=%b ack=%b cnt=%0d data=%h required 0 0 0 00",
               dst_valid, dst_ack_tgl, xfer_cnt, dst_data);
    end
    @(negedge dst_clk);
    rstn = 1'b1;
    dst_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge dst_clk);
      checks++;
      if (dst_valid !== 1'b0 || dst_ack_tgl !== 1'b0 || xfer_cnt !== 8'd0) begin
        errors++;
        $display("FAIL mid_reset_quiet cyc %0d: valid=%b ack=%b cnt=%0d required 0 0 0",
                 i, dst_valid, dst_ack_tgl, xfer_cnt);
      end
    end
  endtask

  initial begin
    rstn = 1'b0;
    src_req_tgl = 1'b0;
    src_data = '0;
    dst_ready = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_proto_violation();
    test_reset_mid_transfer();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vr_cdc_bus_receiver.md
# vr_cdc_bus_receiver

Destination-side endpoint of a two-phase (toggle) request/acknowledge bus crossing into the dst_clk domain. Synchronizes the source request toggle internally, captures the source-held data word, presents it on a valid/ready interface, and returns an acknowledge toggle to the source domain once the word is consumed. Sits directly downstream of the source-domain bus launcher; its dst_ack_tgl is synchronized back in the source domain by a standard synchronizer instance.

## Interface
- WIDTH, 8, data word width (>=1)
- DEPTH, 2, flop stages on the internal src_req_tgl synchronizer (>=2)
- CNT_W, 16, width of the transfer counter
- dst_clk  in  1  destination clock
- rstn  in  1  asynchronous active-low reset
- src_req_tgl  in  1  source request toggle, asynchronous to dst_clk; each transition announces a new word
- src_data  in  WIDTH  source data; held stable by the source from req toggle until it observes the matching ack toggle
- dst_valid  out  1  captured word available
- dst_ready  in  1  consumer accepts word when high with dst_valid
- dst_data  out  WIDTH  captured word, stable while dst_valid is high
- dst_ack_tgl  out  1  acknowledge toggle returned to the source domain (registered, glitch-free)
- proto_err  out  1  sticky: request toggled while a word is still pending
- xfer_cnt  out  CNT_W  number of accepted words, wraps modulo 2^CNT_W

## Operation
- Internal chain req_s[0..DEPTH-1] samples src_req_tgl; req_s[DEPTH-1] is the synchronized request. Register req_seen holds the last serviced request level.
- State IDLE: if req_s[DEPTH-1] != req_seen -> capture dst_data <= src_data, req_seen <= req_s[DEPTH-1], dst_valid <= 1, go BUSY. src_data is sampled only on this edge.
- State BUSY: dst_valid=1, dst_data frozen. On dst_valid && dst_ready: dst_valid <= 0, dst_ack_tgl <= ~dst_ack_tgl, xfer_cnt <= xfer_cnt+1, go IDLE.
- In BUSY, if req_s[DEPTH-1] != req_seen -> proto_err <= 1 (sticky until rstn); the extra toggle is not serviced in BUSY, and on return to IDLE the mismatch is treated as a new request (data as then present on src_data).
- Only ack-on-accept: source cannot launch the next word before the current one is consumed; this is the backpressure path.
- Reset values: all req_s stages 0, req_seen 0, dst_valid 0, dst_data 0, dst_ack_tgl 0, proto_err 0, xfer_cnt 0, state IDLE. Source side must also reset its req toggle to 0.
- Reset asserted mid-transfer: pending word discarded, ack not toggled; outputs return to reset values asynchronously.

## Timing
- src_req_tgl change sampled at edge E0 appears at req_s[DEPTH-1] after edge E0+DEPTH-1; dst_valid rises after edge E0+DEPTH (DEPTH+1 edges from first sample, including capture).
- dst_valid is registered; no combinational path from dst_ready or src_req_tgl to any output.
- Accept edge: dst_valid falls and dst_ack_tgl toggles on the same edge; xfer_cnt updates on that edge.
- dst_ready held high: word spends exactly one cycle in BUSY.
- Minimum dst_clk cycles per word, excluding source-side latency: DEPTH+2 (sync, capture, accept).
- xfer_cnt wraps from 2^CNT_W-1 to 0 without flag.
- src_data and src_req_tgl are false-path/max-delay constrained; data stability guaranteed by protocol, not by sampling order.

## Test plan
- Reset: rstn low with src_req_tgl=1 -> all outputs 0; release rstn -> dst_valid rises DEPTH+1 edges later (pending toggle is seen as request).
- Single transfer, DEPTH=2, dst_ready=1: toggle req with src_data=0xA5 -> dst_valid high one cycle after edge 3, dst_data=0xA5, dst_ack_tgl 0->1, xfer_cnt=1.
- Backpressure: dst_ready=0 for 10 cycles -> dst_valid and dst_data=0x3C held stable, dst_ack_tgl unchanged; dst_ready=1 -> accept, ack toggles once.
- Back-to-back 300 words via a source model that waits for synchronized ack -> every word received in order, no proto_err, xfer_cnt=300 (CNT_W=8: 300 mod 256 = 44).
- Protocol violation: second req toggle while dst_ready=0 -> proto_err=1 and stays 1 after accept; only rstn clears it.
- Reset mid-transfer: rstn asserted while dst_valid=1 -> dst_valid=0, dst_ack_tgl=0, xfer_cnt=0 immediately, no spurious accept after release when source also reset.
